// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - state_t   : RUN/HALT state encoding
//   - SEL_*     : next-PC select codes
//   - clog2     : ceiling log2 (minimum 1) used for return-stack pointer widths
package pc_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [2:0] SEL_HOLD = 3'd0;
  localparam logic [2:0] SEL_SEQ  = 3'd1;
  localparam logic [2:0] SEL_BR   = 3'd2;
  localparam logic [2:0] SEL_JMP  = 3'd3;
  localparam logic [2:0] SEL_RET  = 3'd4;

  // Ceiling log2, never below 1 so a 1-entry stack still gets a real pointer.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << res) < 64'(value)) res = res + 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset    : clock, asynchronous active-high reset (stack empty)
//   i_push        : push i_push_data; when full the oldest entry is overwritten
//   i_pop         : pop the top entry (push wins if both are asserted)
//   o_top_data    : current top-of-stack value (valid when !o_empty)
//   o_empty/o_full: occupancy flags
//   o_err         : registered one-cycle pulse on overflow or underflow
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned LENGTH = 11,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [LENGTH-1:0] i_push_data,
  output logic [LENGTH-1:0] o_top_data,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_err
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [LENGTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;  // next free slot; equals oldest entry when full
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  logic [PTR_W-1:0]  w_rd_ptr;
  logic [PTR_W-1:0]  w_wr_ptr_inc;
  logic              w_do_pop;

  assign w_rd_ptr     = (r_wr_ptr == '0) ? LAST_IDX : r_wr_ptr - 1'b1;
  assign w_wr_ptr_inc = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == FULL_CNT);
  assign o_top_data   = r_mem[w_rd_ptr];
  assign o_err        = r_err;
  assign w_do_pop     = i_pop && !i_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
        if (o_full) r_err   <= 1'b1;
        else        r_count <= r_count + 1'b1;
      end else if (w_do_pop) begin
        if (o_empty) begin
          r_err <= 1'b1;
        end else begin
          r_wr_ptr <= w_rd_ptr;
          r_count  <= r_count - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter unit with next-PC selection and a RUN/HALT machine.
//   clk, reset          : clock, asynchronous active-high reset
//   enable              : 0 stalls the unit (nothing changes)
//   branch_valid/target : taken-branch redirect
//   jump_valid/target   : jump redirect (beats branch)
//   halt / resume       : enter HALT / leave HALT with a sequential advance
//   program_count       : registered PC
//   pc_plus_step        : program_count + STEP (combinational, wraps)
//   halted              : registered, 1 while in HALT
//   update_count        : saturating count of PC writes since reset
// Optional macro PC_RAS_EN adds call_valid, ret_valid, ras_err and a
// RAS_DEPTH-entry return-address stack (pc_ras).
module pc_seq
  import pc_pkg::*;
#(
  parameter int unsigned LENGTH     = 11,
  parameter int unsigned STEP       = 1,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              branch_valid,
  input  logic [LENGTH-1:0] branch_target,
  input  logic              jump_valid,
  input  logic [LENGTH-1:0] jump_target,
  input  logic              halt,
  input  logic              resume,
`ifdef PC_RAS_EN
  input  logic              call_valid,
  input  logic              ret_valid,
  output logic              ras_err,
`endif
  output logic [LENGTH-1:0] program_count,
  output logic [LENGTH-1:0] pc_plus_step,
  output logic              halted,
  output logic [CNT_W-1:0]  update_count
);

  localparam logic [LENGTH-1:0] STEP_L  = LENGTH'(STEP);
  localparam logic [LENGTH-1:0] RESET_L = LENGTH'(RESET_ADDR);

  state_t            r_state;
  logic [LENGTH-1:0] r_pc;
  logic              r_halted;
  logic [CNT_W-1:0]  r_cnt;

  logic [LENGTH-1:0] w_pc_plus;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [2:0]        w_sel;
  logic [LENGTH-1:0] w_next;
  logic              w_call;
  logic              w_ret;
  logic              w_ras_empty;
  logic [LENGTH-1:0] w_ras_top;

  assign w_pc_plus = r_pc + STEP_L;  // modulo 2^LENGTH by truncation
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef PC_RAS_EN
  logic w_push;
  logic w_pop;

  assign w_call = call_valid;
  assign w_ret  = ret_valid;
  // Only act on the stack when the redirect actually wins this edge.
  assign w_push = (w_sel == SEL_JMP) && w_call;
  assign w_pop  = (w_sel == SEL_RET);

  pc_ras #(
    .LENGTH (LENGTH),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_plus),
    .o_top_data  (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (),
    .o_err       (ras_err)
  );
`else
  assign w_call      = 1'b0;
  assign w_ret       = 1'b0;
  assign w_ras_empty = 1'b1;
  assign w_ras_top   = '0;
`endif

  always_comb begin
    w_sel = SEL_HOLD;
    if (enable && (r_state == ST_RUN) && !halt) begin
      if (jump_valid || w_call) w_sel = SEL_JMP;
      else if (w_ret)           w_sel = SEL_RET;
      else if (branch_valid)    w_sel = SEL_BR;
      else                      w_sel = SEL_SEQ;
    end
  end

  always_comb begin
    w_next = r_pc;
    case (w_sel)
      SEL_JMP: w_next = jump_target;
      SEL_RET: w_next = w_ras_empty ? w_pc_plus : w_ras_top;  // underflow falls through
      SEL_BR:  w_next = branch_target;
      SEL_SEQ: w_next = w_pc_plus;
      default: w_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_L;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else if (enable) begin
      case (r_state)
        ST_RUN: begin
          if (halt) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else begin
            r_pc  <= w_next;
            r_cnt <= w_cnt_inc;
          end
        end
        ST_HALT: begin
          if (resume) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_pc     <= w_pc_plus;
            r_cnt    <= w_cnt_inc;
          end
        end
      endcase
    end
  end

  assign program_count = r_pc;
  assign pc_plus_step  = w_pc_plus;
  assign halted        = r_halted;
  assign update_count  = r_cnt;

endmodule

// File: tb/tb_pc_seq.sv
module tb_pc_seq;

  localparam int unsigned LENGTH = 11;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              branch_valid;
  logic [LENGTH-1:0] branch_target;
  logic              jump_valid;
  logic [LENGTH-1:0] jump_target;
  logic              halt;
  logic              resume;
  logic [LENGTH-1:0] program_count;
  logic [LENGTH-1:0] pc_plus_step;
  logic              halted;
  logic [CNT_W-1:0]  update_count;
`ifdef PC_RAS_EN
  logic              call_valid;
  logic              ret_valid;
  logic              ras_err;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_seq #(
    .LENGTH     (LENGTH),
    .STEP       (1),
    .RESET_ADDR (0),
    .CNT_W      (CNT_W),
    .RAS_DEPTH  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .halt          (halt),
    .resume        (resume),
`ifdef PC_RAS_EN
    .call_valid    (call_valid),
    .ret_valid     (ret_valid),
    .ras_err       (ras_err),
`endif
    .program_count (program_count),
    .pc_plus_step  (pc_plus_step),
    .halted        (halted),
    .update_count  (update_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    branch_valid = 1'b0;
    branch_target = '0;
    jump_valid = 1'b0;
    jump_target = '0;
    halt = 1'b0;
    resume = 1'b0;
`ifdef PC_RAS_EN
    call_valid = 1'b0;
    ret_valid = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_pc", 32'(program_count), 32'h0);
    check_eq("reset_halted", 32'(halted), 32'h0);
    check_eq("reset_count", update_count, 32'h0);
    check_eq("reset_plus", 32'(pc_plus_step), 32'h1);
    reset = 1'b0;

    // Sequential advance.
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check_eq($sformatf("seq_pc%0d", i), 32'(program_count), 32'(i));
    end
    check_eq("seq_count", update_count, 32'd5);
    step();
    step();
    check_eq("pc7", 32'(program_count), 32'h7);

    // Jump and branch together: jump wins.
    jump_valid = 1'b1;  jump_target = 11'h100;
    branch_valid = 1'b1; branch_target = 11'h020;
    step();
    check_eq("jump_beats_branch", 32'(program_count), 32'h100);
    jump_valid = 1'b0;
    branch_valid = 1'b0;
    step();
    check_eq("after_jump", 32'(program_count), 32'h101);
    check_eq("count_9", update_count, 32'd9);

    // Branch alone, then wrap at the top of the address space.
    branch_valid = 1'b1; branch_target = 11'h7FE;
    step();
    branch_valid = 1'b0;
    check_eq("branch", 32'(program_count), 32'h7FE);
    step();
    check_eq("pc_7ff", 32'(program_count), 32'h7FF);
    check_eq("plus_wrap", 32'(pc_plus_step), 32'h000);
    step();
    check_eq("wrap_pc", 32'(program_count), 32'h000);
    check_eq("wrap_halted", 32'(halted), 32'h0);
    check_eq("wrap_count", update_count, 32'd12);

    // Stall with a redirect pending: nothing moves.
    enable = 1'b0;
    jump_valid = 1'b1; jump_target = 11'h0AA;
    for (int i = 0; i < 3; i++) step();
    check_eq("stall_pc", 32'(program_count), 32'h000);
    check_eq("stall_count", update_count, 32'd12);

    // Jump to 0x10, then halt together with a jump.
    enable = 1'b1;
    jump_target = 11'h010;
    step();
    check_eq("jump_0x10", 32'(program_count), 32'h010);
    halt = 1'b1;
    jump_target = 11'h055;
    step();
    halt = 1'b0;
    check_eq("halt_pc", 32'(program_count), 32'h010);
    check_eq("halt_flag", 32'(halted), 32'h1);
    check_eq("halt_count", update_count, 32'd13);
    for (int i = 0; i < 4; i++) step();
    check_eq("halt_ignore_jump", 32'(program_count), 32'h010);
    jump_valid = 1'b0;

    // Resume under stall is dropped.
    enable = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    enable = 1'b1;
    step();
    check_eq("resume_stalled_halted", 32'(halted), 32'h1);
    check_eq("resume_stalled_pc", 32'(program_count), 32'h010);

    resume = 1'b1;
    step();
    resume = 1'b0;
    check_eq("resume_pc", 32'(program_count), 32'h011);
    check_eq("resume_halted", 32'(halted), 32'h0);
    check_eq("resume_count", update_count, 32'd14);

    // Halt again, then reset asynchronously between edges.
    halt = 1'b1;
    step();
    halt = 1'b0;
    check_eq("halt2_flag", 32'(halted), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_pc", 32'(program_count), 32'h0);
    check_eq("async_reset_halted", 32'(halted), 32'h0);
    check_eq("async_reset_count", update_count, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("post_reset_run", 32'(program_count), 32'h1);

`ifdef PC_RAS_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("ras_start", 32'(program_count), 32'h5);
    call_valid = 1'b1; jump_target = 11'h040;
    step();
    check_eq("call1_pc", 32'(program_count), 32'h040);
    check_eq("call1_err", 32'(ras_err), 32'h0);
    jump_target = 11'h080;
    step();
    check_eq("call2_pc", 32'(program_count), 32'h080);
    check_eq("call2_err", 32'(ras_err), 32'h0);
    jump_target = 11'h0C0;
    step();
    check_eq("call3_pc", 32'(program_count), 32'h0C0);
    check_eq("call3_overflow", 32'(ras_err), 32'h1);
    call_valid = 1'b0;
    ret_valid = 1'b1;
    step();
    check_eq("ret1_pc", 32'(program_count), 32'h081);
    check_eq("ret1_err", 32'(ras_err), 32'h0);
    step();
    check_eq("ret2_pc", 32'(program_count), 32'h041);
    step();
    check_eq("ret3_pc", 32'(program_count), 32'h042);
    check_eq("ret3_underflow", 32'(ras_err), 32'h1);
    ret_valid = 1'b0;
    step();
    check_eq("after_ret_pc", 32'(program_count), 32'h043);
    check_eq("after_ret_err", 32'(ras_err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Parametrised program-counter unit for the pipelined processor; successor to the plain enable-gated PC register.
- Owns next-PC selection: sequential, branch, jump.
- Adds a RUN/HALT state machine with a resume handshake and a retired-update counter.
- Feeds the instruction-memory address in the fetch stage; stall and redirect controls come from the hazard and branch units.

Parameters:
LENGTH, 11, PC width in bits
STEP, 1, sequential increment (word-addressed memory)
RESET_ADDR, 0, PC value at reset
CNT_W, 32, width of the update counter
RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = PC may update this cycle; 0 = stall, hold everything
branch_valid  in  1  taken-branch redirect request
branch_target  in  LENGTH  branch destination
jump_valid  in  1  jump redirect request
jump_target  in  LENGTH  jump destination
halt  in  1  halt instruction decoded
resume  in  1  leave HALT (single-cycle pulse)
program_count  out  LENGTH  current PC, registered
pc_plus_step  out  LENGTH  program_count + STEP, combinational
halted  out  1  1 while in HALT, registered
update_count  out  CNT_W  number of PC updates since reset
call_valid  in  1  (PC_RAS_EN only) jump and push return address
ret_valid  in  1  (PC_RAS_EN only) return to popped address
ras_err  out  1  (PC_RAS_EN only) one-cycle pulse on overflow or underflow

Behaviour:
- Reset, async, any time, including mid-halt: program_count=RESET_ADDR, state=RUN, halted=0, update_count=0, RAS empty, ras_err=0.
- Addition is modulo 2^LENGTH: STEP added to all-ones wraps to 0 with no flag.
- RUN priority, evaluated per rising edge:
  - enable=0: hold.
  - halt=1: PC holds; go to HALT.
  - jump_valid (or call_valid): PC <= jump_target.
  - ret_valid: PC <= popped address.
  - branch_valid: PC <= branch_target.
  - otherwise: PC <= pc_plus_step.
- Jump beats branch when both are asserted. Halt beats any redirect in the same cycle.
- HALT:
  - PC frozen; all redirect inputs ignored.
  - resume=1 with enable=1: PC <= pc_plus_step, go to RUN.
  - resume while enable=0: ignored and not remembered.
- Latency: the new PC is visible one cycle after the qualifying edge. halted rises in the same cycle the PC first holds.
- update_count:
  - +1 on every edge where program_count is written (sequential, redirect, or resume advance).
  - Holds at the all-ones value (saturates).
  - Not incremented on stall or while halted.

Optional Feature:
Macro PC_RAS_EN.
- Defined:
  - Adds call_valid, ret_valid, ras_err and a RAS_DEPTH-entry return-address stack.
  - call_valid redirects like a jump and pushes pc_plus_step. On a full stack the push overwrites the oldest entry and ras_err pulses.
  - ret_valid pops. On an empty stack the PC takes pc_plus_step and ras_err pulses.
  - call and ret asserted in the same cycle: the call wins, no pop.
- Undefined: these ports and the storage are absent; behaviour is identical to the RAS-enabled build with call/ret tied to 0.

Decomposition:
- Package pc_pkg holds:
  - state encoding: ST_RUN=0, ST_HALT=1;
  - select-code constants SEL_HOLD, SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET;
  - function clog2 for RAS pointer width.
- One natural sub-module, pc_ras: a circular stack with push/pop, full/empty and an error pulse, instantiated only under PC_RAS_EN.

Test Plan:
- Reset, then enable=1 for 5 cycles (LENGTH=11, STEP=1) -> PC 0,1,2,3,4,5; update_count=5.
- At PC=7, assert jump_valid (target 0x100) and branch_valid (target 0x20) together -> PC=0x100 next cycle; then 0x101.
- PC=0x7FF with enable=1 -> PC=0x000, no other flag. Stall for 3 cycles -> PC and update_count unchanged.
- At PC=0x10, assert halt plus jump_valid -> PC stays 0x10 and halted=1. Jump ignored for 4 cycles. resume -> PC=0x11 and halted=0 next cycle. Assert reset mid-halt -> PC=0 and halted=0 immediately, without waiting for a clock edge.
- PC_RAS_EN, RAS_DEPTH=2:
  - call at PC 5 (target 0x40) -> PC=0x40. Call at 0x40 (target 0x80) -> PC=0x80. Third call at 0x80 -> ras_err pulses once.
  - Three rets -> PC 0x81, 0x41, then pc_plus_step 0x42 with ras_err pulse on the underflow.
